// File: rtl/hms_clock_pkg.sv
// hms_clock_pkg
//   Shared definitions for the hours/minutes/seconds timekeeper:
//   - FSM state encodings (CLOCK, SET_SEC, SET_MIN, SET_HOUR)
//   - field maxima for seconds and minutes
//   - default last-hour value (24 h clock)
package hms_clock_pkg;

  typedef enum logic [1:0] {
    CLOCK    = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } state_t;

  localparam logic [5:0] SEC_MAX          = 6'd59;
  localparam logic [5:0] MIN_MAX          = 6'd59;
  localparam int         HOUR_MAX_DEFAULT = 23;

endpackage

// File: rtl/hms_clock_mod_cnt.sv
// mod_cnt
//   Modulo counter for one time field. The counter advances on en and
//   wraps to 0 once the value has reached MAX. The comparison is >=, so an
//   out-of-range value also wraps to 0.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset, clears value
//   en     advance the count this cycle
//   value  registered count
//   wrap   combinational; high when this enable makes the field wrap
module mod_cnt #(
  parameter int               WIDTH = 6,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  assign wrap = en && (value >= MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value <= '0;
    end else if (en) begin
      value <= wrap ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/hms_clock.sv
// hms_clock
//   Seconds/minutes/hours timekeeper. It is driven by a 1 Hz tick pulse and
//   has a set-mode FSM for adjusting the fields by push-button pulses.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   tick       one-cycle 1 Hz pulse
//   mode       one-cycle pulse, advances the set-mode FSM
//   inc        one-cycle pulse, increments the selected field in set mode
//   sec        seconds 0..59
//   min        minutes 0..59
//   hour       hours 0..HOUR_MAX
//   state      current FSM state
//   carry_day  one-cycle pulse on the HOUR_MAX:59:59 -> 00:00:00 rollover
//
// state    | meaning
// CLOCK    | normal timekeeping; tick advances time, inc ignored
// SET_SEC  | time frozen; inc advances seconds only
// SET_MIN  | time frozen; inc advances minutes only
// SET_HOUR | time frozen; inc advances hours only
module hms_clock
  import hms_clock_pkg::*;
#(
  parameter int HOUR_MAX = HOUR_MAX_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       mode,
  input  logic       inc,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [1:0] state,
  output logic       carry_day
);

  localparam logic [4:0] HOUR_MAX_5 = 5'(HOUR_MAX);

  state_t state_q;
  logic   sec_en, min_en, hour_en;
  logic   sec_wrap, min_wrap, hour_wrap;

  // In CLOCK the fields cascade through the wrap flags. In a set state,
  // only the selected field moves and its wrap does not carry.
  always_comb begin
    sec_en  = 1'b0;
    min_en  = 1'b0;
    hour_en = 1'b0;
    case (state_q)
      CLOCK: begin
        sec_en  = tick;
        min_en  = sec_wrap;
        hour_en = min_wrap;
      end
      SET_SEC:  sec_en  = inc;
      SET_MIN:  min_en  = inc;
      SET_HOUR: hour_en = inc;
      default: ;
    endcase
  end

  mod_cnt #(.WIDTH(6), .MAX(SEC_MAX)) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (sec_en),
    .value (sec),
    .wrap  (sec_wrap)
  );

  mod_cnt #(.WIDTH(6), .MAX(MIN_MAX)) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (min_en),
    .value (min),
    .wrap  (min_wrap)
  );

  mod_cnt #(.WIDTH(5), .MAX(HOUR_MAX_5)) u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hour_en),
    .value (hour),
    .wrap  (hour_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLOCK;
      carry_day <= 1'b0;
    end else begin
      // hour_en is driven by the minute wrap only in CLOCK, so a wrap
      // caused by inc in SET_HOUR never raises carry_day.
      carry_day <= (state_q == CLOCK) && hour_wrap;
      if (mode) begin
        case (state_q)
          CLOCK:    state_q <= SET_SEC;
          SET_SEC:  state_q <= SET_MIN;
          SET_MIN:  state_q <= SET_HOUR;
          SET_HOUR: state_q <= CLOCK;
          default:  state_q <= CLOCK;
        endcase
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_hms_clock.sv
module tb_hms_clock;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic mode = 1'b0;
  logic inc = 1'b0;

  logic [5:0] sec_a, min_a, sec_b, min_b;
  logic [4:0] hour_a, hour_b;
  logic [1:0] state_a, state_b;
  logic       carry_a, carry_b;

  // a: 24 h clock, b: 12 h clock. Both receive the same stimulus.
  hms_clock #(.HOUR_MAX(23)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .inc(inc),
    .sec(sec_a), .min(min_a), .hour(hour_a), .state(state_a), .carry_day(carry_a)
  );

  hms_clock #(.HOUR_MAX(11)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick), .mode(mode), .inc(inc),
    .sec(sec_b), .min(min_b), .hour(hour_b), .state(state_b), .carry_day(carry_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model. In CLOCK the time is kept as seconds since midnight.
  int hmax [2] = '{23, 11};
  int m_sec [2], m_min [2], m_hour [2], m_state [2], m_carry [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic t, input logic m, input logic i);
    int total;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        m_sec[k] = 0; m_min[k] = 0; m_hour[k] = 0; m_state[k] = 0; m_carry[k] = 0;
      end else begin
        m_carry[k] = 0;
        case (m_state[k])
          0: if (t) begin
            total = m_hour[k] * 3600 + m_min[k] * 60 + m_sec[k] + 1;
            if (total >= (hmax[k] + 1) * 3600) begin
              total = 0;
              m_carry[k] = 1;
            end
            m_hour[k] = total / 3600;
            m_min[k]  = (total / 60) % 60;
            m_sec[k]  = total % 60;
          end
          1: if (i) m_sec[k]  = (m_sec[k] + 1) % 60;
          2: if (i) m_min[k]  = (m_min[k] + 1) % 60;
          default: if (i) m_hour[k] = (m_hour[k] + 1) % (hmax[k] + 1);
        endcase
        if (m) m_state[k] = (m_state[k] + 1) % 4;
      end
    end
  endtask

  task automatic check_model();
    chk("a.sec",   sec_a,   m_sec[0]);
    chk("a.min",   min_a,   m_min[0]);
    chk("a.hour",  hour_a,  m_hour[0]);
    chk("a.state", state_a, m_state[0]);
    chk("a.carry", carry_a, m_carry[0]);
    chk("b.sec",   sec_b,   m_sec[1]);
    chk("b.min",   min_b,   m_min[1]);
    chk("b.hour",  hour_b,  m_hour[1]);
    chk("b.state", state_b, m_state[1]);
    chk("b.carry", carry_b, m_carry[1]);
  endtask

  task automatic cycle(input logic r, input logic t, input logic m, input logic i);
    rst_n = r; tick = t; mode = m; inc = i;
    @(posedge clk);
    model_step(r, t, m, i);
    #1;
    check_model();
    rst_n = 1'b1; tick = 1'b0; mode = 1'b0; inc = 1'b0;
  endtask

  task automatic incs(input int n);
    for (int j = 0; j < n; j++) cycle(1, 0, 0, 1);
  endtask

  task automatic chk_a(input string name, input int s, input int mi, input int h,
                       input int st, input int c);
    chk({name, ".sec"},   sec_a,   s);
    chk({name, ".min"},   min_a,   mi);
    chk({name, ".hour"},  hour_a,  h);
    chk({name, ".state"}, state_a, st);
    chk({name, ".carry"}, carry_a, c);
  endtask

  typedef struct {
    logic r, t, m, i;
    int   es, em, eh, est, ec;
  } vec_t;

  vec_t tbl [$];

  initial begin
    // Hand-derived vectors for the 24 h instance, starting from reset.
    tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 2, 0, 0, 1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 3, 0, 0, 1, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 3, 0, 0, 1, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 4, 0, 0, 2, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4, 1, 0, 2, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 4, 1, 0, 3, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4, 1, 1, 3, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4, 1, 2, 3, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 4, 1, 2, 0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b0, 1'b1, 4, 1, 2, 0, 0});
    tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 5, 1, 2, 0, 0});
    tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b1, 5, 1, 2, 1, 0});
    tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0});

    for (int v = 0; v < tbl.size(); v++) begin
      cycle(tbl[v].r, tbl[v].t, tbl[v].m, tbl[v].i);
      chk_a($sformatf("tbl%0d", v), tbl[v].es, tbl[v].em, tbl[v].eh, tbl[v].est, tbl[v].ec);
    end

    // 61 ticks from reset: 00:01:01, and carry_day never asserted.
    cycle(0, 0, 0, 0);
    for (int j = 0; j < 61; j++) begin
      cycle(1, 1, 0, 0);
      chk("t1.carry", carry_a, 0);
    end
    chk_a("t1.end", 1, 1, 0, 0, 0);

    // Preload 23:59:58. The 12 h instance wraps 23 incs to hour 11, so it
    // sits at 11:59:58 and exercises its own rollover at the same time.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 0); incs(58);
    cycle(1, 0, 1, 0); incs(59);
    cycle(1, 0, 1, 0); incs(23);
    cycle(1, 0, 1, 0);
    chk_a("t2.pre", 58, 59, 23, 0, 0);
    chk("t2.pre.b.hour", hour_b, 11);
    cycle(1, 1, 0, 0);
    chk_a("t2.tick1", 59, 59, 23, 0, 0);
    chk("t2.tick1.b.hour", hour_b, 11);
    cycle(1, 1, 0, 0);
    chk_a("t2.tick2", 0, 0, 0, 0, 1);
    chk("t2.tick2.b.hour", hour_b, 0);
    chk("t2.tick2.b.carry", carry_b, 1);
    cycle(1, 0, 0, 0);
    chk("t2.after.a.carry", carry_a, 0);
    chk("t2.after.b.carry", carry_b, 0);

    // Seconds wrap in set mode without carry, then ticks frozen in SET_MIN.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 0); incs(59);
    chk_a("t3.sec59", 59, 0, 0, 1, 0);
    incs(1);
    chk_a("t3.wrap", 0, 0, 0, 1, 0);
    cycle(1, 0, 1, 0);
    for (int j = 0; j < 10; j++) cycle(1, 1, 0, 0);
    chk_a("t3.frozen", 0, 0, 0, 2, 0);

    // mode+inc in SET_MIN, then mode+tick in CLOCK.
    incs(5);
    cycle(1, 0, 1, 1);
    chk_a("t4.modeinc", 0, 6, 0, 3, 0);
    cycle(0, 0, 0, 0);
    for (int j = 0; j < 3; j++) cycle(1, 1, 0, 0);
    cycle(1, 1, 1, 0);
    chk_a("t4.modetick", 4, 0, 0, 1, 0);

    // SET_HOUR wrap at 11 on the 12 h instance, with no carry_day.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 0); cycle(1, 0, 1, 0); cycle(1, 0, 1, 0);
    incs(11);
    chk("t5.b.hour11", hour_b, 11);
    incs(1);
    chk("t5.b.hour0", hour_b, 0);
    chk("t5.b.carry", carry_b, 0);
    chk("t5.a.hour12", hour_a, 12);

    // Reset while in SET_HOUR at 07:30:15, together with tick and inc.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 0); incs(15);
    cycle(1, 0, 1, 0); incs(30);
    cycle(1, 0, 1, 0); incs(7);
    chk_a("t6.pre", 15, 30, 7, 3, 0);
    cycle(0, 1, 0, 1);
    chk_a("t6.rst", 0, 0, 0, 0, 0);

    // Random stimulus against the model.
    for (int j = 0; j < 4000; j++) begin
      cycle(($urandom_range(0, 199) != 0),
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hms_clock.md
Name: hms_clock

Overview:
Timekeeping stage directly downstream of the NCO tick generator. It consumes a one-cycle 1 Hz enable pulse and keeps seconds, minutes and hours with cascaded wrap and carry. A 4-state set-mode FSM lets the user adjust each field with two push-button pulses. Outputs feed the display/BCD stage.

Parameters:
HOUR_MAX, 23, last hour value before wrap to 0 (23 = 24 h clock, 11 = 12 h); legal range 1..31.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
tick  input  1  one-cycle pulse in the clk domain, nominally once per second (NCO edge-detect output).
mode  input  1  one-cycle pulse (debounced, edge-detected upstream) that advances the FSM.
inc  input  1  one-cycle pulse that increments the field selected in set mode.
sec  output  6  seconds, 0..59.
min  output  6  minutes, 0..59.
hour  output  5  hours, 0..HOUR_MAX.
state  output  2  current FSM state encoding.
carry_day  output  1  one-cycle pulse when the hour wraps HOUR_MAX->0 in CLOCK state.

Behaviour:
- Reset: rst_n low at a rising clk -> sec=0, min=0, hour=0, state=CLOCK, carry_day=0. Reset is synchronous only; no asynchronous path. It overrides tick/mode/inc in the same cycle. Reset mid-operation, including mid-set, returns to CLOCK with time 00:00:00.
- All outputs are registered. An input pulse sampled at edge N is visible on the outputs after edge N.
- FSM states: CLOCK=2'd0, SET_SEC=2'd1, SET_MIN=2'd2, SET_HOUR=2'd3. mode pulse: CLOCK->SET_SEC->SET_MIN->SET_HOUR->CLOCK. No other transitions exist.
- CLOCK state:
  - tick -> sec+1.
  - sec>=59 -> sec=0 and min+1 on the same edge.
  - sec>=59 and min>=59 -> min=0 and hour+1.
  - All three at max (hour>=HOUR_MAX) -> hour=0 and carry_day=1 for exactly that one cycle.
  - inc is ignored.
- SET_x states:
  - tick is ignored, so time is frozen and ticks are dropped, not queued.
  - inc increments only the selected field. It wraps max->0 with no carry into other fields.
  - carry_day stays 0.
  - Fields are not cleared on entry or exit.
- Wrap comparisons use >= against the max, so any out-of-range value recovers to 0 on the next increment.
- Simultaneous events:
  - mode+inc in a SET state: inc applies to the current state's field, and the state advances on the same edge.
  - mode+tick in CLOCK: the tick is applied and the state moves to SET_SEC.
  - mode+inc in CLOCK: inc is ignored and the state advances.
- carry_day defaults to 0 every cycle unless set by the wrap condition above.
- Widths: increments are unsigned with no overflow beyond the field widths. HOUR_MAX is compared in 5 bits.

Decomposition:
- Shared package:
  - state encodings CLOCK/SET_SEC/SET_MIN/SET_HOUR;
  - constants SEC_MAX=6'd59, MIN_MAX=6'd59;
  - default HOUR_MAX.
- One sub-module, mod_cnt, instantiated three times:
  - parameterised WIDTH and MAX;
  - inputs clk, rst_n, en;
  - outputs the count value and a combinational wrap flag (en && value>=MAX).
- The top level builds the per-field enables from the FSM state, tick, inc and the wrap flags.

Test Plan:
1. Reset then 61 ticks in CLOCK -> sec=1, min=1, hour=0, carry_day never asserted.
2. Preload 23:59:58 via set mode, return to CLOCK, 2 ticks -> after the 1st: 23:59:59; after the 2nd: 00:00:00, with carry_day=1 for exactly one cycle.
3. mode x1 (SET_SEC), set sec=59, then inc once -> sec=0, min unchanged. In SET_MIN apply 10 ticks -> time unchanged.
4. mode and inc in the same cycle while in SET_MIN with min=5 -> min=6 and state=SET_HOUR on the next cycle. mode and tick together in CLOCK at sec=3 -> sec=4 and state=SET_SEC.
5. HOUR_MAX=11: from 11:59:59, one tick -> hour=0 and carry_day pulse. In SET_HOUR, inc at hour=11 -> hour=0.
6. Assert rst_n=0 for one cycle while in SET_HOUR at 07:30:15 together with tick and inc -> next cycle 00:00:00, state=CLOCK, carry_day=0.
